tlcd_bus_sequencer: RTL and testbench

- Owns the character-LCD bus (E/RS/RW/DATA), runs the power-on init sequence, then arbitrates byte writes from two requesters.
- Port A is the custom-font (CGRAM) loader; port B is the text (DDRAM) controller.
- Generates all E-pulse setup/high/hold timing and post-write wait times, so requesters only issue RS+byte through a valid/ready handshake.
- Replaces the hard "font done" mux at top level with a single bus owner.

---
 rtl/tlcd_pkg.sv | 36 +++
 rtl/tlcd_bus_sequencer_engine.sv | 85 ++++++++
 rtl/tlcd_bus_sequencer.sv | 141 ++++++++++++++
 tb/tb_tlcd_bus_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlcd_pkg.sv
// Shared types and constants for the character-LCD bus sequencer.
package tlcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    SETUP,
    PULSE,
    HOLD,
    WAIT,
    IDLE
  } t_state;

  localparam logic [7:0] INIT_CMD_0 = 8'h38;
  localparam logic [7:0] INIT_CMD_1 = 8'h0C;
  localparam logic [7:0] INIT_CMD_2 = 8'h06;
  localparam logic [7:0] INIT_CMD_3 = 8'h01;
  localparam int         INIT_LEN   = 4;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Clear and both home encodings need the long post-write wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == 8'h03);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return INIT_CMD_0;
      2'd1:    return INIT_CMD_1;
      2'd2:    return INIT_CMD_2;
      default: return INIT_CMD_3;
    endcase
  endfunction

endpackage

// File: rtl/tlcd_bus_sequencer_engine.sv
// Single LCD bus write: setup, E pulse, hold and post-write wait.
// state | meaning
// IDLE  | bus parked, waiting for i_start
// SETUP | RS/DATA driven, E low
// PULSE | E high
// HOLD  | E low, RS/DATA held
// WAIT  | LCD execution time; o_done on the last cycle
module tlcd_write_engine
  import tlcd_pkg::*;
#(
  parameter int CNT_W         = 20,
  parameter int E_SETUP_CYC   = 4,
  parameter int E_HIGH_CYC    = 25,
  parameter int E_HOLD_CYC    = 4,
  parameter int CMD_WAIT_CYC  = 2500,
  parameter int LONG_WAIT_CYC = 100000
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_done,
  output logic       o_e,
  output logic       o_rs,
  output logic [7:0] o_data
);

  t_state           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_e;
  logic             r_rs;
  logic [7:0]       r_data;
  logic [CNT_W-1:0] w_last;
  logic             w_phase_end;

  always_comb begin
    w_last = '0;
    case (r_state)
      SETUP:   w_last = CNT_W'(E_SETUP_CYC - 1);
      PULSE:   w_last = CNT_W'(E_HIGH_CYC - 1);
      HOLD:    w_last = CNT_W'(E_HOLD_CYC - 1);
      WAIT:    w_last = is_long_cmd(r_rs, r_data) ? CNT_W'(LONG_WAIT_CYC - 1)
                                                  : CNT_W'(CMD_WAIT_CYC - 1);
      default: w_last = '0;
    endcase
  end

  assign w_phase_end = (r_cnt == w_last);
  // Combinational so the owner can chain the next write on the same edge.
  assign o_done      = (r_state == WAIT) && w_phase_end;

  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_e     <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
    end else if (i_start) begin
      r_state <= SETUP;
      r_cnt   <= '0;
      r_e     <= 1'b0;
      r_rs    <= i_rs;
      r_data  <= i_data;
    end else if (r_state != IDLE) begin
      if (w_phase_end) begin
        r_cnt <= '0;
        case (r_state)
          SETUP: begin r_state <= PULSE; r_e <= 1'b1; end
          PULSE: begin r_state <= HOLD;  r_e <= 1'b0; end
          HOLD:  r_state <= WAIT;
          default: r_state <= IDLE;
        endcase
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_e    = r_e;
  assign o_rs   = r_rs;
  assign o_data = r_data;

endmodule

// File: rtl/tlcd_bus_sequencer.sv
// LCD bus owner: power-on wait, init command list, then A-priority arbitration.
// state    | meaning
// PWR_WAIT | power-on delay after reset release
// SETUP    | a write is in flight in the engine (init or requester)
// IDLE     | init complete, arbitrating A and B
module tlcd_bus_sequencer
  import tlcd_pkg::*;
#(
  parameter int CNT_W         = 20,
  parameter int POWERON_CYC   = 750000,
  parameter int E_SETUP_CYC   = 4,
  parameter int E_HIGH_CYC    = 25,
  parameter int E_HOLD_CYC    = 4,
  parameter int CMD_WAIT_CYC  = 2500,
  parameter int LONG_WAIT_CYC = 100000
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       A_VALID,
  input  logic       A_RS,
  input  logic [7:0] A_DATA,
  input  logic       A_LOCK,
  output logic       A_READY,
  input  logic       B_VALID,
  input  logic       B_RS,
  input  logic [7:0] B_DATA,
  output logic       B_READY,
  output logic       INIT_DONE,
  output logic       BUSY,
  output logic       TLCD_E,
  output logic       TLCD_RS,
  output logic       TLCD_RW,
  output logic [7:0] TLCD_DATA
);

  t_state           r_state;
  logic [CNT_W-1:0] r_pwr_cnt;
  logic [1:0]       r_init_idx;
  logic             r_init_done;
  logic             r_busy;

  logic       w_idle;
  logic       w_pwr_end;
  logic       w_done;
  logic       w_init_last;
  logic       w_init_next;
  logic       w_start;
  logic       w_rs;
  logic [7:0] w_data;

  assign w_idle      = (r_state == IDLE) && r_init_done;
  assign A_READY     = w_idle && A_VALID;
  assign B_READY     = w_idle && B_VALID && !A_VALID && !A_LOCK;
  assign w_pwr_end   = (r_state == PWR_WAIT) && (r_pwr_cnt == CNT_W'(POWERON_CYC - 1));
  assign w_init_last = (r_init_idx == 2'(INIT_LEN - 1));
  assign w_init_next = (r_state == SETUP) && w_done && !r_init_done && !w_init_last;
  assign w_start     = w_pwr_end || w_init_next || A_READY || B_READY;

  always_comb begin
    w_rs   = 1'b0;
    w_data = 8'h00;
    if (A_READY) begin
      w_rs   = A_RS;
      w_data = A_DATA;
    end else if (B_READY) begin
      w_rs   = B_RS;
      w_data = B_DATA;
    end else if (w_pwr_end) begin
      w_data = init_cmd(2'd0);
    end else begin
      w_data = init_cmd(r_init_idx + 2'd1);
    end
  end

  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      r_state     <= PWR_WAIT;
      r_pwr_cnt   <= '0;
      r_init_idx  <= 2'd0;
      r_init_done <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      case (r_state)
        PWR_WAIT: begin
          if (w_pwr_end) begin
            r_pwr_cnt  <= '0;
            r_init_idx <= 2'd0;
            r_state    <= SETUP;
          end else begin
            r_pwr_cnt <= r_pwr_cnt + 1'b1;
          end
        end
        SETUP: begin
          if (w_done) begin
            if (r_init_done) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else if (w_init_last) begin
              r_init_done <= 1'b1;
              r_state     <= IDLE;
              r_busy      <= 1'b0;
            end else begin
              r_init_idx <= r_init_idx + 2'd1;
            end
          end
        end
        IDLE: begin
          if (A_READY || B_READY) begin
            r_state <= SETUP;
            r_busy  <= 1'b1;
          end
        end
        default: r_state <= PWR_WAIT;
      endcase
    end
  end

  tlcd_write_engine #(
    .CNT_W        (CNT_W),
    .E_SETUP_CYC  (E_SETUP_CYC),
    .E_HIGH_CYC   (E_HIGH_CYC),
    .E_HOLD_CYC   (E_HOLD_CYC),
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .LONG_WAIT_CYC(LONG_WAIT_CYC)
  ) u_engine (
    .CLK    (CLK),
    .RESETN (RESETN),
    .i_start(w_start),
    .i_rs   (w_rs),
    .i_data (w_data),
    .o_done (w_done),
    .o_e    (TLCD_E),
    .o_rs   (TLCD_RS),
    .o_data (TLCD_DATA)
  );

  assign INIT_DONE = r_init_done;
  assign BUSY      = r_busy;
  assign TLCD_RW   = 1'b0;

endmodule

// File: tb/tb_tlcd_bus_sequencer.sv
// Scoreboard bench: model predicts grants, bus writes and timing; monitor checks the LCD bus.
module tb_tlcd_bus_sequencer;

  localparam int P  = 20;
  localparam int S  = 2;
  localparam int EH = 4;
  localparam int HO = 2;
  localparam int CW = 10;
  localparam int LW = 50;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic       A_VALID, A_RS, A_LOCK, A_READY;
  logic [7:0] A_DATA;
  logic       B_VALID, B_RS, B_READY;
  logic [7:0] B_DATA;
  logic       INIT_DONE, BUSY, TLCD_E, TLCD_RS, TLCD_RW;
  logic [7:0] TLCD_DATA;

  tlcd_bus_sequencer #(
    .CNT_W(20), .POWERON_CYC(P), .E_SETUP_CYC(S), .E_HIGH_CYC(EH),
    .E_HOLD_CYC(HO), .CMD_WAIT_CYC(CW), .LONG_WAIT_CYC(LW)
  ) dut (
    .CLK(CLK), .RESETN(RESETN),
    .A_VALID(A_VALID), .A_RS(A_RS), .A_DATA(A_DATA), .A_LOCK(A_LOCK), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_RS(B_RS), .B_DATA(B_DATA), .B_READY(B_READY),
    .INIT_DONE(INIT_DONE), .BUSY(BUSY),
    .TLCD_E(TLCD_E), .TLCD_RS(TLCD_RS), .TLCD_RW(TLCD_RW), .TLCD_DATA(TLCD_DATA)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
    end
  endtask

  // kind 0: first init write, 1: chained init write, 2: requester write
  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         kind;
    int         t_xfer;
    bit         last;
  } exp_t;

  exp_t q[$];

  function automatic int wait_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'd1 && d <= 8'd3) ? LW : CW;
  endfunction

  // Monitor: reference model of grants/idle plus bus-side scoreboard.
  initial begin
    exp_t cur;
    bit   prev_e = 0, prev_rst = 1, idle_armed = 0, idle_is_init = 0, done_flag = 0;
    bit   model_idle, exp_a, exp_b;
    int   rel_cyc = 0, idle_at = 0, chain_at = 0, rise_t = 0;
    logic [7:0] init_list [4];
    init_list[0] = 8'h38; init_list[1] = 8'h0C; init_list[2] = 8'h06; init_list[3] = 8'h01;
    cur = '{rs: 1'b0, data: 8'h00, kind: 0, t_xfer: 0, last: 1'b0};
    forever begin
      @(negedge CLK);
      if (RESETN) begin
        check("rst_e", int'(TLCD_E), 0);
        check("rst_rs", int'(TLCD_RS), 0);
        check("rst_data", int'(TLCD_DATA), 0);
        check("rst_busy", int'(BUSY), 1);
        check("rst_init_done", int'(INIT_DONE), 0);
        check("rst_ready", int'({A_READY, B_READY}), 0);
        q.delete();
        idle_armed = 0; done_flag = 0; prev_e = 0; prev_rst = 1;
        continue;
      end
      if (prev_rst) begin
        rel_cyc = cyc;
        for (int i = 0; i < 4; i++)
          q.push_back('{rs: 1'b0, data: init_list[i], kind: (i == 0) ? 0 : 1, t_xfer: 0, last: (i == 3)});
        prev_rst = 0;
      end
      model_idle = idle_armed && (cyc >= idle_at);
      if (model_idle && idle_is_init) done_flag = 1;
      exp_a = model_idle && A_VALID;
      exp_b = model_idle && B_VALID && !A_VALID && !A_LOCK;
      check("a_ready", int'(A_READY), int'(exp_a));
      check("b_ready", int'(B_READY), int'(exp_b));
      check("busy", int'(BUSY), int'(!model_idle));
      check("init_done", int'(INIT_DONE), int'(done_flag));
      check("rw", int'(TLCD_RW), 0);
      if (exp_a) q.push_back('{rs: A_RS, data: A_DATA, kind: 2, t_xfer: cyc, last: 1'b0});
      else if (exp_b) q.push_back('{rs: B_RS, data: B_DATA, kind: 2, t_xfer: cyc, last: 1'b0});
      if (exp_a || exp_b) begin idle_armed = 0; idle_is_init = 0; end
      if (TLCD_E && !prev_e) begin
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_pulse: rs=%0b data=0x%0h with nothing expected", TLCD_RS, TLCD_DATA);
        end else begin
          cur = q.pop_front();
          check("bus_rs", int'(TLCD_RS), int'(cur.rs));
          check("bus_data", int'(TLCD_DATA), int'(cur.data));
          if (cur.kind == 0)      check("e_rise_cycle", cyc, rel_cyc + P + S);
          else if (cur.kind == 1) check("e_rise_cycle", cyc, chain_at + S);
          else                    check("e_rise_cycle", cyc, cur.t_xfer + 1 + S);
        end
        rise_t = cyc;
      end
      if (!TLCD_E && prev_e) begin
        check("e_high_cycles", cyc - rise_t, EH);
        if (cur.kind != 2 && !cur.last) chain_at = cyc + HO + wait_len(cur.rs, cur.data);
        else begin
          idle_at = cyc + HO + wait_len(cur.rs, cur.data);
          idle_armed = 1;
          idle_is_init = cur.last;
        end
      end
      prev_e = TLCD_E;
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin @(negedge CLK); n++; end while ((BUSY || !INIT_DONE) && n < budget);
    if (BUSY || !INIT_DONE) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: busy=%0b init_done=%0b, required busy=0 init_done=1", BUSY, INIT_DONE);
    end
  endtask

  task automatic send_a(input logic rs, input logic [7:0] d, input logic lock,
                        input logic lock_after, input int dly);
    int n = 0;
    @(posedge CLK); #1;
    A_LOCK = lock;
    repeat (dly) @(posedge CLK);
    #1;
    A_VALID = 1'b1; A_RS = rs; A_DATA = d;
    do begin @(negedge CLK); n++; end while (!A_READY && n < 5000);
    if (!A_READY) begin
      n_tests++; n_fail++;
      $display("FAIL a_grant_timeout: a_ready=%0b, required 1", A_READY);
    end
    @(posedge CLK); #1;
    A_VALID = 1'b0;
    A_LOCK  = lock_after;
  endtask

  task automatic send_b(input logic rs, input logic [7:0] d, input int dly);
    int n = 0;
    @(posedge CLK);
    repeat (dly) @(posedge CLK);
    #1;
    B_VALID = 1'b1; B_RS = rs; B_DATA = d;
    do begin @(negedge CLK); n++; end while (!B_READY && n < 5000);
    if (!B_READY) begin
      n_tests++; n_fail++;
      $display("FAIL b_grant_timeout: b_ready=%0b, required 1", B_READY);
    end
    @(posedge CLK); #1;
    B_VALID = 1'b0;
  endtask

  initial begin
    RESETN = 1'b1;
    A_VALID = 0; A_RS = 0; A_DATA = 8'h00; A_LOCK = 0;
    B_VALID = 0; B_RS = 0; B_DATA = 8'h00;
    repeat (3) @(posedge CLK);
    #1 RESETN = 1'b0;
    wait_idle(2000);

    send_b(1'b1, 8'h46, 0);
    wait_idle(500);

    fork
      send_a(1'b0, 8'h80, 1'b0, 1'b0, 0);
      send_b(1'b1, 8'h41, 0);
    join
    wait_idle(500);

    fork
      begin
        send_a(1'b0, 8'h40, 1'b1, 1'b1, 0);
        for (int i = 0; i < 8; i++)
          send_a(1'b1, 8'($urandom_range(0, 255)), 1'b1, (i != 7), (i == 3) ? 25 : 0);
      end
      send_b(1'b1, 8'h5A, 0);
    join
    wait_idle(500);

    send_a(1'b0, 8'h02, 1'b0, 1'b0, 0);
    wait_idle(500);
    send_a(1'b0, 8'h80, 1'b0, 1'b0, 0);
    wait_idle(500);

    for (int it = 0; it < 16; it++) begin
      bit do_a, do_b;
      logic [7:0] da, db;
      do_a = 1'($urandom_range(0, 1));
      do_b = 1'($urandom_range(0, 1)) || !do_a;
      da = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
      db = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
      fork
        if (do_a) send_a(1'($urandom_range(0, 1)), da, 1'($urandom_range(0, 1)), 1'b0,
                         $urandom_range(0, 4));
        if (do_b) send_b(1'($urandom_range(0, 1)), db, $urandom_range(0, 4));
      join
      wait_idle(500);
    end

    fork
      send_b(1'b1, 8'h33, 0);
      begin
        int n = 0;
        do begin @(negedge CLK); n++; end while (!TLCD_E && n < 200);
        if (!TLCD_E) begin
          n_tests++; n_fail++;
          $display("FAIL pulse_wait_timeout: e=%0b, required 1", TLCD_E);
        end
        @(posedge CLK);
        #3 RESETN = 1'b1;
        #1;
        check("async_rst_e", int'(TLCD_E), 0);
        check("async_rst_data", int'(TLCD_DATA), 0);
        check("async_rst_busy", int'(BUSY), 1);
      end
    join
    repeat (3) @(posedge CLK);
    #1 RESETN = 1'b0;
    wait_idle(2000);
    send_b(1'b1, 8'h21, 0);
    wait_idle(500);

    repeat (5) @(negedge CLK);
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
